// File: rtl/mant_mult_seq.sv
// Sequential radix-2 shift-add significand multiplier with exponent sum and sign.
// Accepts one operand pair, spends sig_width+1 cycles multiplying, then holds the result until taken.
module mant_mult_seq #(
    parameter int sig_width = 23,
    parameter int ex_width  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [sig_width-1:0]     mant_a,
    input  logic [sig_width-1:0]     mant_b,
    input  logic [ex_width-1:0]      exp_a,
    input  logic [ex_width-1:0]      exp_b,
    input  logic                     sign_a,
    input  logic                     sign_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*sig_width+1:0]   mant_mult,
    output logic [ex_width+1:0]      exp_sub,
    output logic                     sign_out
);

    localparam int P_W   = 2*sig_width + 3;
    localparam int CNT_W = $clog2(sig_width + 1);
    localparam int BIAS  = 2**(ex_width-1) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [P_W-1:0]       p_q, p_step;
    logic [sig_width:0]   m_q;
    logic [CNT_W-1:0]     count_q;
    logic [sig_width+1:0] acc_hi;
    logic [ex_width+1:0]  exp_sum;
    logic                 accept;

    assign accept    = in_valid & in_ready;
    assign mant_mult = p_q[2*sig_width+1:0];

    // Operands zero-extended by two bits so the biased sum can never wrap.
    assign exp_sum = {2'b00, exp_a} + {2'b00, exp_b} - (ex_width+2)'(BIAS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MULT;
            MULT:    if (count_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One shift-add step: conditionally add M into the upper half, then shift the whole accumulator.
    always_comb begin
        acc_hi = p_q[P_W-1:sig_width+1];
        if (p_q[0]) begin
            acc_hi = acc_hi + {1'b0, m_q};
        end
        p_step = {acc_hi, p_q[sig_width:0]} >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q      <= '0;
            m_q      <= '0;
            count_q  <= '0;
            exp_sub  <= '0;
            sign_out <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        m_q      <= {1'b1, mant_a};
                        p_q      <= {{(sig_width+2){1'b0}}, 1'b1, mant_b};
                        exp_sub  <= exp_sum;
                        sign_out <= sign_a ^ sign_b;
                        count_q  <= CNT_W'(sig_width);
                    end
                end
                MULT: begin
                    p_q     <= p_step;
                    count_q <= count_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mant_mult_seq.sv
// Self-checking bench for mant_mult_seq: directed vector table, random operands vs an arithmetic
// reference, plus hand-written back-pressure and mid-operation reset sequences.
module tb_mant_mult_seq;

    localparam int SW = 23;
    localparam int EW = 8;
    localparam int LAT = SW + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [SW-1:0]   mant_a = '0;
    logic [SW-1:0]   mant_b = '0;
    logic [EW-1:0]   exp_a = '0;
    logic [EW-1:0]   exp_b = '0;
    logic            sign_a = 1'b0;
    logic            sign_b = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [2*SW+1:0] mant_mult;
    logic [EW+1:0]   exp_sub;
    logic            sign_out;

    int errors = 0;
    int checks = 0;

    mant_mult_seq #(.sig_width(SW), .ex_width(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant_a    (mant_a),
        .mant_b    (mant_b),
        .exp_a     (exp_a),
        .exp_b     (exp_b),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mant_mult (mant_mult),
        .exp_sub   (exp_sub),
        .sign_out  (sign_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0]   a;
        logic [SW-1:0]   b;
        logic [EW-1:0]   ea;
        logic [EW-1:0]   eb;
        logic            sa;
        logic            sb;
        logic [2*SW+1:0] exp_mant;
        logic [EW+1:0]   exp_exp;
        logic            exp_sign;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Reference: plain integer arithmetic on the real significands and exponents.
    function automatic logic [2*SW+1:0] ref_mant(input logic [SW-1:0] a, input logic [SW-1:0] b);
        longint unsigned ma, mb;
        ma = longint'(a) + (longint'(1) << SW);
        mb = longint'(b) + (longint'(1) << SW);
        return (2*SW+2)'(ma * mb);
    endfunction

    function automatic logic [EW+1:0] ref_exp(input logic [EW-1:0] ea, input logic [EW-1:0] eb);
        int e;
        e = int'(ea) + int'(eb) - (2**(EW-1) - 1);
        return (EW+2)'(e);
    endfunction

    task automatic drive(input logic [SW-1:0] a, input logic [SW-1:0] b,
                         input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                         input logic sa, input logic sb);
        mant_a = a; mant_b = b; exp_a = ea; exp_b = eb; sign_a = sa; sign_b = sb;
        in_valid = 1'b1;
    endtask

    // Called at a negedge with in_valid high; returns at the negedge of the first MULT cycle.
    task automatic wait_accept(input string name);
        int w = 0;
        while (!in_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check({name, "_accept_timeout"}, 64'(in_ready), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            check({name, "_done_timeout"}, 64'(out_valid), 64'd1);
        end
    endtask

    task automatic run_op(input string name, input logic [SW-1:0] a, input logic [SW-1:0] b,
                          input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                          input logic sa, input logic sb,
                          input logic [2*SW+1:0] wm, input logic [EW+1:0] we, input logic ws,
                          input bit chk_lat);
        int lat;
        @(negedge clk);
        drive(a, b, ea, eb, sa, sb);
        wait_accept(name);
        wait_done(name, lat);
        check({name, "_mant"}, 64'(mant_mult), 64'(wm));
        check({name, "_exp"},  64'(exp_sub),   64'(we));
        check({name, "_sign"}, 64'(sign_out),  64'(ws));
        check({name, "_norm"}, 64'(mant_mult[2*SW+1] | mant_mult[2*SW]), 64'd1);
        if (chk_lat) check({name, "_latency"}, 64'(lat), 64'(LAT));
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs[5];
        int   lat;
        int   seen;
        logic [2*SW+1:0] held_m;
        logic [EW+1:0]   held_e;
        logic [SW-1:0] ra, rb;
        logic [EW-1:0] rea, reb;
        logic rsa, rsb;

        vecs[0] = '{23'h000000, 23'h000000, 8'd127, 8'd127, 1'b0, 1'b1, 48'h4000_0000_0000, 10'd127, 1'b1};
        vecs[1] = '{23'h400000, 23'h400000, 8'd130, 8'd120, 1'b0, 1'b0, 48'h9000_0000_0000, 10'd123, 1'b0};
        vecs[2] = '{23'h7FFFFF, 23'h7FFFFF, 8'd1,   8'd1,   1'b1, 1'b0, 48'hFFFF_FE00_0001, 10'h383, 1'b1};
        vecs[3] = '{23'h000000, 23'h000000, 8'd254, 8'd254, 1'b1, 1'b1, 48'h4000_0000_0000, 10'h17D, 1'b0};
        vecs[4] = '{23'h7FFFFF, 23'h000000, 8'd1,   8'd254, 1'b1, 1'b1, 48'h7FFF_FF80_0000, 10'd128, 1'b0};

        // Reset state and in_ready rising one cycle after release.
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mant",      64'(mant_mult), 64'd0);
        check("rst_exp",       64'(exp_sub),   64'd0);
        check("rst_sign",      64'(sign_out),  64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_in_ready", 64'(in_ready), 64'd1);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ea, vecs[i].eb,
                   vecs[i].sa, vecs[i].sb, vecs[i].exp_mant, vecs[i].exp_exp, vecs[i].exp_sign, 1'b1);
        end

        for (int i = 0; i < 20; i++) begin
            ra  = SW'($urandom);
            rb  = SW'($urandom);
            rea = EW'($urandom_range(1, 254));
            reb = EW'($urandom_range(1, 254));
            rsa = 1'($urandom);
            rsb = 1'($urandom);
            run_op($sformatf("rand%0d", i), ra, rb, rea, reb, rsa, rsb,
                   ref_mant(ra, rb), ref_exp(rea, reb), rsa ^ rsb, 1'b0);
        end

        // Back-pressure: result held for 6 cycles while a new operand waits.
        out_ready = 1'b0;
        @(negedge clk);
        drive(23'h123456, 23'h654321, 8'd100, 8'd60, 1'b1, 1'b0);
        wait_accept("stall");
        wait_done("stall", lat);
        held_m = mant_mult;
        held_e = exp_sub;
        check("stall_mant", 64'(held_m), 64'(ref_mant(23'h123456, 23'h654321)));
        check("stall_exp",  64'(held_e), 64'(ref_exp(8'd100, 8'd60)));
        drive(23'h0ABCDE, 23'h7F0F0F, 8'd200, 8'd10, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("stall_hold_valid", 64'(out_valid), 64'd1);
            check("stall_hold_ready", 64'(in_ready),  64'd0);
            check("stall_hold_mant",  64'(mant_mult), 64'(held_m));
            check("stall_hold_exp",   64'(exp_sub),   64'(held_e));
            check("stall_hold_sign",  64'(sign_out),  64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_valid", 64'(out_valid), 64'd0);
        check("stall_release_ready", 64'(in_ready),  64'd1);
        wait_accept("stall_next");
        wait_done("stall_next", lat);
        check("stall_next_latency", 64'(lat), 64'(LAT));
        check("stall_next_mant", 64'(mant_mult), 64'(ref_mant(23'h0ABCDE, 23'h7F0F0F)));
        check("stall_next_exp",  64'(exp_sub),   64'(ref_exp(8'd200, 8'd10)));
        check("stall_next_sign", 64'(sign_out),  64'd0);
        @(negedge clk);

        // Reset during the tenth MULT cycle discards the product.
        @(negedge clk);
        drive(23'h7FFFFF, 23'h7FFFFF, 8'd200, 8'd200, 1'b1, 1'b0);
        wait_accept("abort");
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready",  64'(in_ready),  64'd0);
        check("abort_mant",      64'(mant_mult), 64'd0);
        check("abort_exp",       64'(exp_sub),   64'd0);
        check("abort_sign",      64'(sign_out),  64'd0);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_valid", 64'(seen), 64'd0);
        run_op("after_abort", 23'h2AAAAA, 23'h155555, 8'd127, 8'd3, 1'b0, 1'b1,
               ref_mant(23'h2AAAAA, 23'h155555), ref_exp(8'd127, 8'd3), 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
